fpu_result_fifo: RTL

Result-side buffer for the floating-point pipeline. It accepts completed results and their IEEE exception flags from the last pipeline stage, holds them in a small FIFO, and hands them to the writeback consumer over a valid/ready handshake. It also keeps a sticky OR of all accepted exception flags (fflags). The synchronous `flush` matches the flush the pipeline registers already use, so a pipeline flush clears both ends in the same cycle.

---
 rtl/fpu_result_fifo.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fpu_result_fifo.sv
// rtl/fpu_result_fifo.sv - result/exception-flag buffer between the FP pipeline and writeback
//
// Holds completed FP results and their IEEE exception flags in a small FIFO.
// It hands them to the writeback consumer over a valid/ready handshake. It also
// keeps a sticky OR of the flags of every accepted result.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   flush         synchronous flush; drops all buffered entries, blocks writes
//   in_valid      producer has a result this cycle
//   in_result     result data (WIDTH)
//   in_flags      exception flags for the result (FLAGW, bit 4 = NV)
//   in_ready      buffer can accept (not full, no flush, not in reset)
//   out_valid     head entry is available
//   out_result    head entry data
//   out_flags     head entry flags
//   out_ready     consumer takes the head entry
//   count         occupied entries, 0..DEPTH
//   sticky_flags  OR of flags of all accepted writes since the last clear
//   clr_sticky    synchronous clear of sticky_flags

module fpu_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int FLAGW = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_result,
    input  logic [FLAGW-1:0]         in_flags,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_result,
    output logic [FLAGW-1:0]         out_flags,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [FLAGW-1:0]         sticky_flags,
    input  logic                     clr_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra MSB so that full and empty are distinguishable
    // without a separate occupancy counter.
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    logic [WIDTH-1:0] mem_result [DEPTH];
    logic [FLAGW-1:0] mem_flags  [DEPTH];

    logic             empty;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // in_ready is held low while reset is asserted, even though the pointers
    // already read as empty, so the producer never sees a ready during reset.
    // A full FIFO does not accept in the same cycle as a read: there is no
    // pass-through, and the freed slot shows up as in_ready one cycle later.
    assign in_ready  = reset && !full && !flush;
    assign out_valid = !empty;

    assign wr_en = in_valid && in_ready;
    assign rd_en = out_valid && out_ready;

    assign count = wr_ptr - rd_ptr;

    // Head entry is read straight out of storage; the storage is reset so
    // the outputs are 0 right after reset.
    assign out_result = mem_result[rd_ptr[AW-1:0]];
    assign out_flags  = mem_flags[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            // A read handshake in the flush cycle is swallowed by the flush.
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_result[i] <= '0;
                mem_flags[i]  <= '0;
            end
        end else if (wr_en) begin
            mem_result[wr_ptr[AW-1:0]] <= in_result;
            mem_flags[wr_ptr[AW-1:0]]  <= in_flags;
        end
    end

    // clr_sticky wipes the accumulated value first, so a clear coinciding
    // with a write leaves exactly that write's flags. Flush does not touch it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_flags <= '0;
        end else begin
            sticky_flags <= (clr_sticky ? '0 : sticky_flags) | (wr_en ? in_flags : '0);
        end
    end

endmodule
